// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, load-use/branch handling,
// data-memory handshake FSM with timeout, and a saturating stall-cycle counter.
//
// state  | meaning
// S_IDLE | no access outstanding; a request that is not acked this cycle moves to S_WAIT
// S_WAIT | access outstanding; pipeline frozen until ack or timeout
module hazard_ctrl #(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [4:0]       i_rs1_addrD,
   input  logic [4:0]       i_rs2_addrD,
   input  logic [4:0]       i_rs1_addrE,
   input  logic [4:0]       i_rs2_addrE,
   input  logic [4:0]       i_rd_addrE,
   input  logic             i_rd_wrenE,
   input  logic             i_is_loadE,
   input  logic             i_br_takenE,
   input  logic [4:0]       i_rd_addrM,
   input  logic             i_rd_wrenM,
   input  logic             i_mem_reqM,
   input  logic [4:0]       i_rd_addrW,
   input  logic             i_rd_wrenW,
   input  logic             i_dmem_ack,
   output logic             o_dmem_req,
   output logic             o_dmem_err,
   output logic             o_stallF,
   output logic             o_stallD,
   output logic             o_stallE,
   output logic             o_stallM,
   output logic             o_flushD,
   output logic             o_flushE,
   output logic             o_flushW,
   output logic [1:0]       o_fwd_aE,
   output logic [1:0]       o_fwd_bE,
   output logic [CNT_W-1:0] o_stall_cnt
);

   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_WAIT = 1'b1;

   logic [0:0]       r_state;
   logic [TW-1:0]    r_tmo_cnt;
   logic [CNT_W-1:0] r_stall_cnt;

   logic w_tmo;
   logic w_memstall;
   logic w_lu;
   logic w_any_stall;

   function automatic logic [1:0] fwd_sel(
      input logic [4:0] rs,
      input logic [4:0] rd_m, input logic wr_m,
      input logic [4:0] rd_w, input logic wr_w);
      if (wr_m && rd_m != 5'd0 && rd_m == rs)      return 2'b10;
      else if (wr_w && rd_w != 5'd0 && rd_w == rs) return 2'b01;
      else                                         return 2'b00;
   endfunction

   // Timeout fires on the TIMEOUT-th WAIT cycle unless ack arrives in the same cycle.
   assign w_tmo = (r_state == S_WAIT) && (r_tmo_cnt == TW'(TIMEOUT - 1)) && !i_dmem_ack;

   assign w_memstall = ((r_state == S_IDLE) && i_mem_reqM && !i_dmem_ack) ||
                       ((r_state == S_WAIT) && !i_dmem_ack && !w_tmo);

   assign w_lu = i_is_loadE && (i_rd_addrE != 5'd0) &&
                 ((i_rd_addrE == i_rs1_addrD) || (i_rd_addrE == i_rs2_addrD));

   always_comb begin
      o_dmem_req = 1'b0;
      o_dmem_err = 1'b0;
      o_stallF   = 1'b0;
      o_stallD   = 1'b0;
      o_stallE   = 1'b0;
      o_stallM   = 1'b0;
      o_flushD   = 1'b1;
      o_flushE   = 1'b1;
      o_flushW   = 1'b1;
      o_fwd_aE   = 2'b00;
      o_fwd_bE   = 2'b00;
      if (!i_rst) begin
         o_dmem_req = (r_state == S_IDLE) ? i_mem_reqM : !w_tmo;
         o_dmem_err = w_tmo;
         o_fwd_aE   = fwd_sel(i_rs1_addrE, i_rd_addrM, i_rd_wrenM, i_rd_addrW, i_rd_wrenW);
         o_fwd_bE   = fwd_sel(i_rs2_addrE, i_rd_addrM, i_rd_wrenM, i_rd_addrW, i_rd_wrenW);
         o_stallF   = w_memstall || (w_lu && !i_br_takenE);
         o_stallD   = w_memstall || (w_lu && !i_br_takenE);
         o_stallE   = w_memstall;
         o_stallM   = w_memstall;
         o_flushD   = !w_memstall && i_br_takenE;
         o_flushE   = !w_memstall && (i_br_takenE || w_lu);
         o_flushW   = w_memstall;
      end
   end

   assign w_any_stall = o_stallF || o_stallD || o_stallE || o_stallM;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= S_IDLE;
         r_tmo_cnt <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_tmo_cnt <= '0;
               if (i_mem_reqM && !i_dmem_ack) r_state <= S_WAIT;
            end
            default: begin
               if (i_dmem_ack || w_tmo) begin
                  r_state   <= S_IDLE;
                  r_tmo_cnt <= '0;
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + TW'(1);
               end
            end
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst)                            r_stall_cnt <= '0;
      else if (w_any_stall && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
   end

   assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed and randomized bench for hazard_ctrl against a cycle-level reference model.
module tb_hazard_ctrl;
   localparam int TIMEOUT = 4;
   localparam int CNT_W   = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
   logic wrE, ldE, brE, wrM, reqM, wrW, ack;
   logic dreq, derr, sF, sD, sE, sM, fD, fE, fW;
   logic [1:0] fa, fb;
   logic [CNT_W-1:0] scnt;

   hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_rs1_addrD(rs1D), .i_rs2_addrD(rs2D), .i_rs1_addrE(rs1E), .i_rs2_addrE(rs2E),
      .i_rd_addrE(rdE), .i_rd_wrenE(wrE), .i_is_loadE(ldE), .i_br_takenE(brE),
      .i_rd_addrM(rdM), .i_rd_wrenM(wrM), .i_mem_reqM(reqM),
      .i_rd_addrW(rdW), .i_rd_wrenW(wrW), .i_dmem_ack(ack),
      .o_dmem_req(dreq), .o_dmem_err(derr),
      .o_stallF(sF), .o_stallD(sD), .o_stallE(sE), .o_stallM(sM),
      .o_flushD(fD), .o_flushE(fE), .o_flushW(fW),
      .o_fwd_aE(fa), .o_fwd_bE(fb), .o_stall_cnt(scnt));

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model state: outstanding access, WAIT cycles already spent, stall total.
   bit m_wait;
   int m_waited;
   int m_cnt;

   function automatic int fwd_ref(input logic [4:0] rs);
      if (wrM && rdM != 0 && rdM == rs) return 2;
      if (wrW && rdW != 0 && rdW == rs) return 1;
      return 0;
   endfunction

   // Apply current inputs for one cycle: check outputs mid-cycle, then advance the model.
   task automatic cyc();
      bit ms, lu, tmo, e_req, e_err, e_sFD, e_sEM, e_fD, e_fE, e_fW;
      int e_fa, e_fb;
      #2;
      tmo = m_wait && (m_waited + 1 == TIMEOUT) && !ack;
      ms  = (!m_wait && reqM && !ack) || (m_wait && !ack && !tmo);
      lu  = ldE && rdE != 0 && (rdE == rs1D || rdE == rs2D);
      if (rst) begin
         e_req = 0; e_err = 0; e_sFD = 0; e_sEM = 0;
         e_fD = 1; e_fE = 1; e_fW = 1; e_fa = 0; e_fb = 0;
      end else begin
         e_req = m_wait ? !tmo : reqM;
         e_err = tmo;
         e_sFD = ms || (lu && !brE);
         e_sEM = ms;
         e_fD  = !ms && brE;
         e_fE  = !ms && (brE || lu);
         e_fW  = ms;
         e_fa  = fwd_ref(rs1E);
         e_fb  = fwd_ref(rs2E);
      end
      chk("dmem_req", dreq, e_req);
      chk("dmem_err", derr, e_err);
      chk("stallF", sF, e_sFD);
      chk("stallD", sD, e_sFD);
      chk("stallE", sE, e_sEM);
      chk("stallM", sM, e_sEM);
      chk("flushD", fD, e_fD);
      chk("flushE", fE, e_fE);
      chk("flushW", fW, e_fW);
      chk("fwd_aE", fa, e_fa);
      chk("fwd_bE", fb, e_fb);
      chk("stall_cnt", scnt, m_cnt);
      @(posedge clk);
      if (rst) begin
         m_wait = 0; m_waited = 0; m_cnt = 0;
      end else begin
         if (e_sFD || e_sEM) m_cnt = (m_cnt < 2**CNT_W - 1) ? m_cnt + 1 : m_cnt;
         if (!m_wait) begin
            if (reqM && !ack) begin m_wait = 1; m_waited = 0; end
         end else if (ack || tmo) begin
            m_wait = 0; m_waited = 0;
         end else begin
            m_waited++;
         end
      end
      #1;
   endtask

   task automatic idle_inputs();
      rst = 0; rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
      wrE = 0; ldE = 0; brE = 0; wrM = 0; reqM = 0; wrW = 0; ack = 0;
   endtask

   int base;

   initial begin
      idle_inputs();
      rst = 1;
      m_wait = 0; m_waited = 0; m_cnt = 0;
      @(posedge clk); #1;
      cyc();
      rst = 0;

      // Forwarding priority and zero register
      rdM = 5; wrM = 1; rdW = 5; wrW = 1; rs1E = 5; cyc();
      chk("fwd_mem_prio", fa, 2'b10);
      wrM = 0; cyc();
      chk("fwd_wb", fa, 2'b01);
      rs1E = 0; rdM = 0; rdW = 0; wrM = 1; cyc();
      chk("fwd_x0", fa, 2'b00);
      idle_inputs();

      // Load-use, rdE=0, branch overriding load-use
      ldE = 1; rdE = 7; rs2D = 7; cyc();
      rdE = 0; cyc();
      rdE = 7; brE = 1; cyc();
      idle_inputs(); cyc();

      // Memory wait of 3 cycles, then immediate ack
      base = m_cnt;
      reqM = 1;
      repeat (3) cyc();
      ack = 1; cyc();
      chk("memwait_stall_delta", m_cnt - base, 3);
      reqM = 1; ack = 1; cyc();
      reqM = 0; ack = 0; cyc();

      // Timeout without ack, then ack on the timeout cycle
      reqM = 1;
      repeat (TIMEOUT) cyc();
      reqM = 0; cyc();
      reqM = 1;
      repeat (TIMEOUT) cyc();
      ack = 1; cyc();
      idle_inputs(); cyc();

      // Reset mid-WAIT, branch held during WAIT
      reqM = 1; cyc(); cyc();
      rst = 1; cyc();
      rst = 0; reqM = 0; cyc();
      reqM = 1; brE = 1; cyc(); cyc();
      ack = 1; cyc();
      idle_inputs(); cyc();

      // Randomized traffic; request is held while an access is outstanding
      for (int i = 0; i < 600; i++) begin
         rst  = ($urandom_range(0, 49) == 0);
         rs1D = 5'($urandom_range(0, 3)); rs2D = 5'($urandom_range(0, 3));
         rs1E = 5'($urandom_range(0, 3)); rs2E = 5'($urandom_range(0, 3));
         rdE  = 5'($urandom_range(0, 3)); rdM  = 5'($urandom_range(0, 3));
         rdW  = 5'($urandom_range(0, 3));
         wrE  = 1'($urandom); ldE = 1'($urandom); wrM = 1'($urandom); wrW = 1'($urandom);
         brE  = ($urandom_range(0, 3) == 0);
         reqM = m_wait ? 1'b1 : ($urandom_range(0, 2) == 0);
         ack  = ($urandom_range(0, 2) == 0);
         cyc();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage pipeline. Drives stall/flush enables for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and the EX-stage forwarding mux selects. Runs a data-memory handshake FSM that freezes the pipeline while a variable-latency load/store is outstanding. Keeps a saturating stall-cycle counter for performance debug.

Parameters:
TIMEOUT, 64, maximum WAIT cycles before the memory access is abandoned (>=1)
CNT_W, 16, width of the stall-cycle counter

Ports:
i_clk  in  1  clock, rising edge
i_rst  in  1  synchronous reset, active-high
i_rs1_addrD  in  5  rs1 of instruction in ID
i_rs2_addrD  in  5  rs2 of instruction in ID
i_rs1_addrE  in  5  rs1 of instruction in EX
i_rs2_addrE  in  5  rs2 of instruction in EX
i_rd_addrE  in  5  rd in EX
i_rd_wrenE  in  1  EX instruction writes rd
i_is_loadE  in  1  EX instruction is a load
i_br_takenE  in  1  branch/jump resolved taken in EX
i_rd_addrM  in  5  rd in MEM
i_rd_wrenM  in  1  MEM instruction writes rd
i_mem_reqM  in  1  MEM instruction is a load/store
i_rd_addrW  in  5  rd in WB
i_rd_wrenW  in  1  WB instruction writes rd
i_dmem_ack  in  1  data memory completes access this cycle
o_dmem_req  out  1  data memory request
o_dmem_err  out  1  one-cycle pulse on access timeout
o_stallF  out  1  hold PC
o_stallD  out  1  hold IF/ID
o_stallE  out  1  hold ID/EX
o_stallM  out  1  hold EX/MEM
o_flushD  out  1  clear IF/ID to bubble
o_flushE  out  1  clear ID/EX to bubble
o_flushW  out  1  load bubble into MEM/WB
o_fwd_aE  out  2  EX operand A select: 00 regfile, 01 WB, 10 MEM
o_fwd_bE  out  2  EX operand B select, same encoding
o_stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset (i_rst=1 at edge): state=IDLE, timeout counter=0, o_stall_cnt=0. While i_rst=1, outputs forced: all stalls 0, o_flushD/E/W=1, o_dmem_req=0, o_dmem_err=0, fwd=00.
- Forwarding (combinational, per operand): 10 if i_rd_wrenM && rdM!=0 && rdM==rsE; else 01 if i_rd_wrenW && rdW!=0 && rdW==rsE; else 00. MEM has priority over WB.
- Load-use: lu = i_is_loadE && i_rd_addrE!=0 && (rdE==rs1D || rdE==rs2D) -> stallF=1, stallD=1, flushE=1.
- Branch: i_br_takenE -> flushD=1, flushE=1, and stallF/stallD forced 0, which overrides load-use.
- Memory FSM, states IDLE and WAIT:
  - IDLE: o_dmem_req=i_mem_reqM. If req && ack, the access completes with zero stall. If req && !ack, go to WAIT, and memstall=1 this cycle. Ack without req is ignored.
  - WAIT: o_dmem_req=1 and memstall=1 until ack. On the ack cycle: memstall=0, next state IDLE, counter cleared.
  - Timeout counter increments each WAIT cycle. When it reaches TIMEOUT-1 without ack: o_dmem_err=1 for that cycle, o_dmem_req=0, memstall=0, next IDLE. Ack on that same cycle wins and suppresses err.
- memstall=1 overrides all of the above: stallF/D/E/M=1, flushD=0, flushE=0, flushW=1, fwd selects unchanged.
  - A taken branch or load-use held in EX is applied on the release cycle, because the EX inputs are frozen.
- i_mem_reqM and i_rd_addrM must stay stable while stalled; the block does not check this.
- o_stall_cnt increments on every cycle where any o_stall* is 1, saturating at all-ones.
- Reset asserted mid-WAIT: return to IDLE on the next edge, drop req, no err pulse.

Test Plan:
- Forwarding: rdM=5 wrenM=1, rdW=5 wrenW=1, rs1E=5 -> fwd_aE=10. Then wrenM=0 -> 01. Then rs1E=0 with rdM=rdW=0 -> 00.
- Load-use: is_loadE=1, rdE=7, rs2D=7, no branch, no mem -> stallF=stallD=flushE=1 for 1 cycle. With rdE=0 -> no stall.
- Branch vs load-use: br_takenE=1 plus the load-use condition -> flushD=flushE=1, stallF=stallD=0.
- Mem wait: mem_reqM=1, ack low for 3 cycles, then high -> dmem_req=1 for 4 cycles, stallF..M=1 and flushW=1 for 3 cycles, 0 on the ack cycle. o_stall_cnt +3. Immediate ack -> 0 stall cycles.
- Timeout: TIMEOUT=4, ack never -> stall for 4 cycles, err=1 on the 4th, state IDLE after. Ack on the 4th cycle -> err=0.
- Reset mid-WAIT, and branch during memstall: i_rst=1 during WAIT -> next cycle state IDLE, req=0, flushD/E/W=1. br_takenE=1 during WAIT -> flushD/E=0 until ack, then =1 on the ack cycle.
